// File: rtl/mem_access_if.sv
// Data-bus bundle between the MEM stage (master) and the data memory/bus fabric (slave).
interface mem_access_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
);
    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_ack;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata,
        output bus_rdata, bus_ack
    );
endinterface

// File: rtl/mem_access.sv
// MEM pipeline stage: runs one req/ack bus transaction per load/store, stalls upstream until done,
// and presents writeback data; misaligned word accesses and bus timeouts pulse mem_err.
module mem_access #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned REG_W   = 5,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mem_memrw,
    input  logic [ADDR_W-1:0] mem_memaddr,
    input  logic [DATA_W-1:0] mem_memdata,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [REG_W-1:0]  mem_waddr,
    input  logic              mem_we,
    mem_access_if.master      dbus,
    output logic              stall_req,
    output logic              mem_err,
    output logic [DATA_W-1:0] wb_wdata,
    output logic [REG_W-1:0]  wb_waddr,
    output logic              wb_we
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              load_q, load_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic op_valid;
    logic is_load;
    logic stall_raw;

    assign op_valid = (mem_memrw == 2'b01) || (mem_memrw == 2'b10);
    assign is_load  = (mem_memrw == 2'b01);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        load_d    = load_q;
        rdata_d   = rdata_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        stall_raw = 1'b0;

        case (state_q)
            StIdle: begin
                cnt_d = '0;
                err_d = 1'b0;
                if (op_valid) begin
                    stall_raw = 1'b1;
                    load_d    = is_load;
                    if (mem_memaddr[1:0] == 2'b00) begin
                        req_d   = 1'b1;
                        we_d    = ~is_load;
                        addr_d  = mem_memaddr;
                        wdata_d = mem_memdata;
                        state_d = StWait;
                    end else begin
                        // Misaligned: skip the bus, but a load must still write back zero.
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = StDone;
                    end
                end
            end
            StWait: begin
                stall_raw = 1'b1;
                cnt_d     = cnt_q + 1'b1;
                // Ack takes priority over a coincident timeout.
                if (dbus.bus_ack) begin
                    if (load_q) begin
                        rdata_d = dbus.bus_rdata;
                    end
                    state_d = StDone;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = StDone;
                end
                if (state_d == StDone) begin
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    addr_d  = '0;
                    wdata_d = '0;
                end
            end
            StDone: begin
                err_d   = 1'b0;
                cnt_d   = '0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            load_q  <= 1'b0;
            rdata_q <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            load_q  <= load_d;
            rdata_q <= rdata_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign dbus.bus_req   = req_q;
    assign dbus.bus_we    = we_q;
    assign dbus.bus_addr  = addr_q;
    assign dbus.bus_wdata = wdata_q;

    // Gate with reset so the pipeline is released the moment reset asserts.
    assign stall_req = rst & stall_raw;
    assign wb_we     = rst & mem_we & ~stall_raw;
    assign wb_waddr  = mem_waddr;
    assign mem_err   = (state_q == StDone) & err_q;
    assign wb_wdata  = ((state_q == StDone) && load_q) ? rdata_q : mem_wdata;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: a transaction-level timeline model drives per-cycle expectations
// checked by one compare process, plus literal checks on observed cycle counts and data.
module tb_mem_access;

    localparam int TO = 4;

    logic        clk;
    logic        rst;
    logic [1:0]  mem_memrw;
    logic [31:0] mem_memaddr;
    logic [31:0] mem_memdata;
    logic [31:0] mem_wdata;
    logic [4:0]  mem_waddr;
    logic        mem_we;
    logic        stall_req;
    logic        mem_err;
    logic [31:0] wb_wdata;
    logic [4:0]  wb_waddr;
    logic        wb_we;

    mem_access_if #(.DATA_W(32), .ADDR_W(32)) dbus ();

    mem_access #(
        .DATA_W (32),
        .ADDR_W (32),
        .REG_W  (5),
        .TIMEOUT(TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_memrw  (mem_memrw),
        .mem_memaddr(mem_memaddr),
        .mem_memdata(mem_memdata),
        .mem_wdata  (mem_wdata),
        .mem_waddr  (mem_waddr),
        .mem_we     (mem_we),
        .dbus       (dbus),
        .stall_req  (stall_req),
        .mem_err    (mem_err),
        .wb_wdata   (wb_wdata),
        .wb_waddr   (wb_waddr),
        .wb_we      (wb_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    logic        chk_en = 1'b0;
    logic        exp_stall, exp_req, exp_bwe, exp_err, exp_wbwe;
    logic [31:0] exp_addr, exp_bwdata, exp_wbdata;
    logic [4:0]  exp_wbaddr;

    int          obs_cycles, obs_stall, obs_req;
    logic [31:0] obs_wd;
    logic        obs_err, obs_wbwe;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        vec_cnt++;
        if (act !== want) begin
            miss_cnt++;
            $display("FAIL %s at %0t: got %h, want %h", nm, $time, act, want);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("stall_req", {31'd0, stall_req}, {31'd0, exp_stall});
            chk("bus_req",   {31'd0, dbus.bus_req}, {31'd0, exp_req});
            chk("bus_we",    {31'd0, dbus.bus_we}, {31'd0, exp_bwe});
            chk("bus_addr",  dbus.bus_addr, exp_addr);
            chk("bus_wdata", dbus.bus_wdata, exp_bwdata);
            chk("mem_err",   {31'd0, mem_err}, {31'd0, exp_err});
            chk("wb_we",     {31'd0, wb_we}, {31'd0, exp_wbwe});
            chk("wb_waddr",  {27'd0, wb_waddr}, {27'd0, exp_wbaddr});
            chk("wb_wdata",  wb_wdata, exp_wbdata);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        obs_cycles++;
        if (stall_req) obs_stall++;
        if (dbus.bus_req) obs_req++;
        obs_wd   = wb_wdata;
        obs_err  = mem_err;
        obs_wbwe = wb_we;
    endtask

    task automatic set_exp(input logic st, input logic rq, input logic bwe, input logic [31:0] ad,
                           input logic [31:0] bwd, input logic er, input logic wbwe,
                           input logic [4:0] wba, input logic [31:0] wbd);
        exp_stall  = st;
        exp_req    = rq;
        exp_bwe    = bwe;
        exp_addr   = ad;
        exp_bwdata = bwd;
        exp_err    = er;
        exp_wbwe   = wbwe;
        exp_wbaddr = wba;
        exp_wbdata = wbd;
        chk_en     = 1'b1;
    endtask

    // One pipeline op: ack_after = WAIT cycles before ack (negative = never).
    task automatic do_op(input logic [1:0] rw, input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [31:0] alu, input logic [4:0] wa, input logic we,
                         input int ack_after, input logic [31:0] rd, input logic idle_noise,
                         input logic late_ack);
        logic valid, load, aligned, acked;
        int   nwait;
        valid   = (rw == 2'b01) || (rw == 2'b10);
        load    = (rw == 2'b01);
        aligned = (addr[1:0] == 2'b00);
        acked   = (ack_after >= 0) && (ack_after < TO);
        nwait   = acked ? ack_after + 1 : TO;
        obs_cycles = 0;
        obs_stall  = 0;
        obs_req    = 0;

        next_cycle();
        mem_memrw   = rw;
        mem_memaddr = addr;
        mem_memdata = sdata;
        mem_wdata   = alu;
        mem_waddr   = wa;
        mem_we      = we;
        dbus.bus_ack   = idle_noise;
        dbus.bus_rdata = 32'hBAD0BAD0;
        set_exp(valid, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, we & ~valid, wa, alu);
        sample();
        if (!valid) return;

        if (aligned) begin
            for (int i = 0; i < nwait; i++) begin
                next_cycle();
                dbus.bus_ack   = acked && (i == ack_after);
                dbus.bus_rdata = dbus.bus_ack ? rd : ~rd;
                set_exp(1'b1, 1'b1, ~load, addr, sdata, 1'b0, 1'b0, wa, alu);
                sample();
            end
        end

        next_cycle();
        dbus.bus_ack   = late_ack;
        dbus.bus_rdata = 32'h5A5A5A5A;
        set_exp(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, ~(aligned & acked), we, wa,
                load ? ((aligned && acked) ? rd : 32'd0) : alu);
        sample();
    endtask

    initial begin
        rst = 1'b1;
        mem_memrw = 2'b00;
        mem_memaddr = '0;
        mem_memdata = '0;
        mem_wdata = '0;
        mem_waddr = '0;
        mem_we = 1'b0;
        dbus.bus_ack = 1'b0;
        dbus.bus_rdata = '0;
        #1 rst = 1'b0;
        #1;
        chk("rst_bus_req", {31'd0, dbus.bus_req}, 32'd0);
        chk("rst_stall",   {31'd0, stall_req}, 32'd0);
        chk("rst_err",     {31'd0, mem_err}, 32'd0);
        chk("rst_wb_we",   {31'd0, wb_we}, 32'd0);
        chk("rst_addr",    dbus.bus_addr, 32'd0);
        #20 rst = 1'b1;

        // Idle passthrough.
        do_op(2'b00, 32'h0000_0102, 32'h0, 32'h0000_0055, 5'd3, 1'b1, -1, 32'h0, 1'b0, 1'b0);
        chk("lit_idle_wbwe", {31'd0, obs_wbwe}, 32'd1);
        chk("lit_idle_wd", obs_wd, 32'h0000_0055);

        // Load, ack 3 cycles after req.
        do_op(2'b01, 32'h0000_0100, 32'h0, 32'hAAAA_0001, 5'd7, 1'b1, 3, 32'hCAFE_F00D, 1'b0, 1'b0);
        chk("lit_load_stall", obs_stall, 32'd5);
        chk("lit_load_wd", obs_wd, 32'hCAFE_F00D);
        chk("lit_load_wbwe", {31'd0, obs_wbwe}, 32'd1);

        // Store, ack in first WAIT cycle; stray ack in IDLE is ignored.
        do_op(2'b10, 32'h0000_0204, 32'h1234_5678, 32'h0000_0099, 5'd9, 1'b0, 0, 32'h0, 1'b1, 1'b0);
        chk("lit_store_cycles", obs_cycles, 32'd3);
        chk("lit_store_err", {31'd0, obs_err}, 32'd0);

        // Misaligned load.
        do_op(2'b01, 32'h0000_0102, 32'h0, 32'h0000_0077, 5'd4, 1'b1, 0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        chk("lit_mis_req", obs_req, 32'd0);
        chk("lit_mis_err", {31'd0, obs_err}, 32'd1);
        chk("lit_mis_wd", obs_wd, 32'd0);
        chk("lit_mis_stall", obs_stall, 32'd1);

        // Timeout with a late ack in DONE.
        do_op(2'b01, 32'h0000_0300, 32'h0, 32'h0000_0011, 5'd5, 1'b1, -1, 32'h0, 1'b0, 1'b1);
        chk("lit_to_req", obs_req, 32'd4);
        chk("lit_to_err", {31'd0, obs_err}, 32'd1);
        chk("lit_to_wd", obs_wd, 32'd0);

        // Ack on the final WAIT cycle beats the timeout.
        do_op(2'b01, 32'h0000_0310, 32'h0, 32'h0, 5'd6, 1'b1, TO - 1, 32'h0BAD_CAFE, 1'b0, 1'b0);
        chk("lit_tie_err", {31'd0, obs_err}, 32'd0);

        // Back-to-back loads.
        do_op(2'b01, 32'h0000_0400, 32'h0, 32'h0, 5'd1, 1'b1, 0, 32'h1111_1111, 1'b0, 1'b0);
        chk("lit_b2b_0", obs_wd, 32'h1111_1111);
        do_op(2'b01, 32'h0000_0404, 32'h0, 32'h0, 5'd2, 1'b1, 0, 32'h2222_2222, 1'b0, 1'b0);
        chk("lit_b2b_1", obs_wd, 32'h2222_2222);

        // memrw 11 is idle; misaligned store keeps ALU writeback.
        do_op(2'b11, 32'h0000_0500, 32'h0, 32'h0000_0033, 5'd8, 1'b1, -1, 32'h0, 1'b0, 1'b0);
        do_op(2'b10, 32'h0000_0206, 32'hFEED_BEEF, 32'h0000_0044, 5'd10, 1'b1, 0, 32'h0, 1'b0,
              1'b0);
        chk("lit_mis_st_wd", obs_wd, 32'h0000_0044);

        // Reset asserted mid-WAIT.
        next_cycle();
        chk_en = 1'b0;
        mem_memrw = 2'b01;
        mem_memaddr = 32'h0000_0600;
        mem_we = 1'b1;
        dbus.bus_ack = 1'b0;
        next_cycle();
        chk("rw_req_before", {31'd0, dbus.bus_req}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("rw_req_after", {31'd0, dbus.bus_req}, 32'd0);
        chk("rw_stall_after", {31'd0, stall_req}, 32'd0);
        mem_memrw = 2'b00;
        #5 rst = 1'b1;
        do_op(2'b00, 32'h0, 32'h0, 32'h0000_0066, 5'd12, 1'b1, -1, 32'h0, 1'b0, 1'b0);
        chk("lit_post_rst_stall", obs_stall, 32'd0);

        next_cycle();
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
